// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// streams them one bit per clock, with a one-word pending buffer for gapless runs.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             d_out_q, d_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;

  logic [WIDTH-1:0] sreg_shift;
  logic             xfer;

  // The bit on show always sits at the head end of sreg; shifting drops it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  assign in_ready = !pend_full_q;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    frame_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          sreg_d        = in_data;
          cnt_d         = '0;
          state_d       = SHIFT;
          frame_start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          sreg_d = sreg_shift;
          cnt_d  = cnt_q + 1'b1;
          if (xfer) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
          end
        end else if (pend_full_q) begin
          // in_ready is low here, so no new word can collide with the reload
          sreg_d        = pend_q;
          pend_full_d   = 1'b0;
          cnt_d         = '0;
          frame_start_d = 1'b1;
        end else if (xfer) begin
          sreg_d        = in_data;
          cnt_d         = '0;
          frame_start_d = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bit_valid_d = (state_d == SHIFT);
    d_out_d     = (state_d == SHIFT) ? head_bit(sreg_d) : IDLE_BIT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      cnt_q         <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      d_out_q       <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      d_out_q       <= d_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign d_out       = d_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = bit_valid_q | pend_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench: two serializer instances (MSB-first/idle 0 and LSB-first/idle 1)
// share one stimulus stream; each accepted word is expanded into an expected bit queue.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;

  logic a_dout, a_bv, a_fs, a_rdy, a_busy;
  logic b_dout, b_bv, b_fs, b_rdy, b_busy;

  int n_vec = 0;
  int n_err = 0;

  // Expected stream per instance: entry = {frame_start, d_out}
  logic [1:0] exp_q [2][$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_rdy), .d_out(a_dout), .bit_valid(a_bv),
    .frame_start(a_fs), .busy(a_busy)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_rdy), .d_out(b_dout), .bit_valid(b_bv),
    .frame_start(b_fs), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop the bit on show, check handshake/busy against remaining work, then
  // enqueue the word that will be accepted at the coming edge.
  task automatic monitor(input int d, input logic dout, input logic bv, input logic fs,
                         input logic rdy, input logic bsy, input logic idle_bit,
                         input logic msb_first);
    logic [1:0] e;
    int sz;
    if (bv) begin
      if (exp_q[d].size() == 0) begin
        chk($sformatf("dut%0d_unexpected_bit", d), 1, 0);
      end else begin
        e = exp_q[d].pop_front();
        chk($sformatf("dut%0d_d_out", d), dout, e[0]);
        chk($sformatf("dut%0d_frame_start", d), fs, e[1]);
      end
    end else begin
      chk($sformatf("dut%0d_gap_pending_bits", d), exp_q[d].size(), 0);
      chk($sformatf("dut%0d_idle_d_out", d), dout, idle_bit);
      chk($sformatf("dut%0d_idle_frame_start", d), fs, 0);
    end
    sz = exp_q[d].size();
    chk($sformatf("dut%0d_in_ready", d), rdy, (sz < W) ? 1 : 0);
    chk($sformatf("dut%0d_busy", d), bsy, (bv || sz >= W) ? 1 : 0);
    if (in_valid && rdy) begin
      $display("xfer dut%0d word=%02h", d, in_data);
      for (int i = 0; i < W; i++) begin
        e[0] = msb_first ? in_data[W-1-i] : in_data[i];
        e[1] = (i == 0);
        exp_q[d].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      monitor(0, a_dout, a_bv, a_fs, a_rdy, a_busy, 1'b0, 1'b1);
      monitor(1, b_dout, b_bv, b_fs, b_rdy, b_busy, 1'b1, 1'b0);
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data = w;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (a_rdy) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", done, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #2;
    chk("rst_a_d_out", a_dout, 0);
    chk("rst_b_d_out", b_dout, 1);
    chk("rst_a_bit_valid", a_bv, 0);
    chk("rst_a_frame_start", a_fs, 0);
    chk("rst_a_in_ready", a_rdy, 1);
    chk("rst_a_busy", a_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'h90);
    idle(12);
    send(8'hA5);
    send(8'h3C);
    idle(20);
    send(8'h01);
    idle(10);
    send(8'hC3);
    send(8'h5A);
    send(8'h96);
    idle(30);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 10));
      send(8'($urandom));
    end
    idle(30);

    // Reset while 8'hFF is mid-flight with a word pending behind it.
    send(8'hFF);
    send(8'h5A);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_a_d_out", a_dout, 0);
    chk("midrst_b_d_out", b_dout, 1);
    chk("midrst_a_bit_valid", a_bv, 0);
    chk("midrst_b_bit_valid", b_bv, 0);
    chk("midrst_a_in_ready", a_rdy, 1);
    chk("midrst_a_busy", a_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(20);

    send(8'h81);
    for (int t = 0; t < 40 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); t++)
      @(posedge clk);
    idle(2);
    chk("drain_a", exp_q[0].size(), 0);
    chk("drain_b", exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clk on d_out, a continuous bit stream that the detector samples every cycle.
- A one-word pending buffer allows back-to-back words with no idle gap.
- Drives a fixed IDLE_BIT when no word is in flight.

Parameters:
- WIDTH, 8, word length in bits (>=2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- IDLE_BIT, 0, value driven on d_out when not shifting.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word; equals !pend_full; combinational from state only, never from in_valid.
- d_out  output  1  registered serial bit (feeds detector d).
- bit_valid  output  1  registered; 1 while d_out carries a data bit.
- frame_start  output  1  registered; 1 during the first bit of each word.
- busy  output  1  bit_valid | pend_full.

Behaviour:
- Storage:
  - shift register sreg[WIDTH]
  - bit counter cnt (0..WIDTH-1)
  - pending register pend[WIDTH] with flag pend_full
  - state IDLE / SHIFT
- Handshake: a transfer occurs at an edge where in_valid && in_ready. Data is captured on that edge. in_valid without in_ready is ignored; the source must hold it.
- Reset (async): state=IDLE, pend_full=0, cnt=0, d_out=IDLE_BIT, bit_valid=0, frame_start=0. The in-flight word and the pending word are discarded and never resumed. After release, in_ready=1.
- IDLE:
  - On transfer: load in_data into sreg, cnt=0, state=SHIFT. Starting from that edge: d_out=first bit, bit_valid=1, frame_start=1.
  - Latency: the first bit appears 1 cycle after the transfer edge.
- SHIFT: each edge advances one bit. Every bit is held exactly one clk. frame_start=0 after the first bit.
  - If cnt<WIDTH-1 and a transfer occurs: the word goes to pend, pend_full=1.
  - If cnt==WIDTH-1 (last bit showing), priority at the next edge:
    - (a) pend_full=1: load pend into sreg, pend_full=0, frame_start=1. No gap. in_ready was 0 this cycle, so no simultaneous transfer.
    - (b) pend_full=0 and a transfer occurs: load in_data directly into sreg, frame_start=1. No gap.
    - (c) otherwise: state=IDLE, d_out=IDLE_BIT, bit_valid=0.
- Bit order:
  - MSB_FIRST=1: d_out = sreg[WIDTH-1], shift left.
  - MSB_FIRST=0: d_out = sreg[0], shift right.
- Throughput: with continuous input, exactly one new word every WIDTH cycles. bit_valid stays high continuously.
- in_ready is low only while pend_full=1, i.e. at most WIDTH-1 cycles per word.
- d_out never glitches. All data outputs are driven directly from flops.

Test Plan:
- Reset, then transfer 8'h90 with MSB_FIRST=1 -> d_out 1,0,0,1,0,0,0,0 on the 8 cycles after the transfer edge. bit_valid=1 for exactly those 8 cycles. frame_start=1 on the first only. Downstream detector dout=1 one cycle after the 4th bit. Then d_out=0 and bit_valid=0.
- Transfer 8'hA5 and 8'h3C on consecutive cycles -> 16 contiguous bit_valid cycles, d_out=10100101_00111100. frame_start high at bit 0 and bit 8. in_ready low from the second transfer edge until 8'h3C loads into sreg.
- Hold in_valid high with three words -> third word stalls (in_ready=0) until the first word's last bit shifts out. All 24 bits are emitted in order with no gaps.
- MSB_FIRST=0, send 8'h01 -> d_out 1,0,0,0,0,0,0,0.
- Assert rst after the 3rd bit of 8'hFF with a word pending -> d_out=IDLE_BIT, bit_valid=0, in_ready=1 immediately after reset. The remaining bits and the pending word are never emitted.
- IDLE_BIT=1 with no input -> d_out constant 1, bit_valid=0, busy=0.
